// File: rtl/pipe_rr_issuer_pkg.sv
// Shared types for the round-robin issuer of a fixed-latency unit.
// Default tag width tracks the default requester count.
package pipe_issue_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int TAG_W       = $clog2(NUM_REQ_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } issue_state_e;

    typedef logic [TAG_W-1:0] tag_t;

endpackage

// File: rtl/pipe_rr_issuer_if.sv
// Requester, control and unit-side signals of the issuer.
// master drives the inputs, slave is the issuer itself.
interface pipe_rr_issuer_if #(
    parameter int NUM_REQ = 4,
    parameter int DWIDTH  = 32
);

    logic                            i_enable;
    logic                            i_drain;
    logic                            i_flush;
    logic [NUM_REQ-1:0]              i_req;
    logic [NUM_REQ-1:0][DWIDTH-1:0]  i_req_data;
    logic [NUM_REQ-1:0]              o_grant;
    logic                            o_pipe_valid;
    logic [DWIDTH-1:0]               o_pipe_data;
    logic [DWIDTH-1:0]               i_pipe_result;
    logic [NUM_REQ-1:0]              o_rsp_valid;
    logic [DWIDTH-1:0]               o_rsp_data;
    logic                            o_idle;

    modport slave (
        input  i_enable, i_drain, i_flush,
        input  i_req, i_req_data, i_pipe_result,
        output o_grant, o_pipe_valid, o_pipe_data,
        output o_rsp_valid, o_rsp_data, o_idle
    );

    modport master (
        output i_enable, i_drain, i_flush,
        output i_req, i_req_data, i_pipe_result,
        input  o_grant, o_pipe_valid, o_pipe_data,
        input  o_rsp_valid, o_rsp_data, o_idle
    );

endinterface

// File: rtl/pipe_rr_issuer_valid_pipe.sv
// Delay line carrying {valid,tag} alongside the shared unit.
// Every stage resets and clears on flush so no stale op survives.
module valid_pipe #(
    parameter int LATENCY = 3,
    parameter int TAG_W   = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [TAG_W-1:0] out_tag,
    output logic             any_valid
);

    logic [LATENCY-1:0]            v;
    logic [LATENCY-1:0][TAG_W-1:0] t;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v <= '0;
            t <= '0;
        end else begin
            v[0] <= in_valid & ~flush;
            t[0] <= in_tag;
            for (int i = 1; i < LATENCY; i++) begin
                v[i] <= v[i-1] & ~flush;
                t[i] <= t[i-1];
            end
        end
    end

    assign out_valid = v[LATENCY-1];
    assign out_tag   = t[LATENCY-1];
    assign any_valid = |v;

endmodule

// File: rtl/pipe_rr_issuer.sv
// Round-robin issuer sharing one fixed-latency pipelined unit,
// with per-requester credits, tag return path and run/drain FSM.
module pipe_rr_issuer
    import pipe_issue_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DWIDTH  = 32,
    parameter int LATENCY = 3,
    parameter int MAX_OUT = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    pipe_rr_issuer_if.slave bus
);

    localparam int TW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(MAX_OUT + 1);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_DRAIN = DRAIN;

    logic [1:0]                  state;
    logic [TW-1:0]               ptr;
    logic [NUM_REQ-1:0][CW-1:0]  cnt;
    logic [NUM_REQ-1:0]          elig;
    logic [NUM_REQ-1:0]          grant;
    logic [TW-1:0]               gidx;
    logic                        found;
    logic                        grant_ok;
    logic                        pipe_valid;
    logic [DWIDTH-1:0]           pipe_data;
    logic [TW-1:0]               pipe_tag;
    logic [NUM_REQ-1:0]          rsp_valid;
    logic [DWIDTH-1:0]           rsp_data;
    logic                        line_valid;
    logic [TW-1:0]               line_tag;
    logic                        line_any;
    logic                        empty;
    int                          idx;

    assign grant_ok = (state == ST_RUN) & bus.i_enable
                    & ~bus.i_drain & ~bus.i_flush;

    // A response returning this cycle frees its credit for reuse
    always_comb begin
        elig = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            elig[k] = bus.i_req[k] & grant_ok
                    & ((cnt[k] < CW'(MAX_OUT)) | rsp_valid[k]);
        end
    end

    always_comb begin
        gidx  = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && elig[idx]) begin
                found = 1'b1;
                gidx  = TW'(idx);
            end
        end
    end

    always_comb begin
        grant = '0;
        if (found) grant[gidx] = 1'b1;
    end

    assign empty = ~pipe_valid & ~line_any & ~(|rsp_valid);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE:
                    if (bus.i_enable) state <= ST_RUN;
                ST_RUN:
                    if (bus.i_drain || !bus.i_enable)
                        state <= ST_DRAIN;
                ST_DRAIN:
                    if (empty && !bus.i_drain) state <= ST_IDLE;
                default:
                    state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (bus.i_flush) begin
            cnt <= '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (grant[k] && !rsp_valid[k])
                    cnt[k] <= cnt[k] + CW'(1);
                else if (!grant[k] && rsp_valid[k])
                    cnt[k] <= cnt[k] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_valid <= 1'b0;
            pipe_data  <= '0;
            pipe_tag   <= '0;
        end else begin
            pipe_valid <= found & ~bus.i_flush;
            if (found) begin
                pipe_data <= bus.i_req_data[gidx];
                pipe_tag  <= gidx;
            end
        end
    end

    // Tag rides beside the unit so it emerges with its result
    valid_pipe #(
        .LATENCY (LATENCY),
        .TAG_W   (TW)
    ) u_line (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (bus.i_flush),
        .in_valid  (pipe_valid),
        .in_tag    (pipe_tag),
        .out_valid (line_valid),
        .out_tag   (line_tag),
        .any_valid (line_any)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= '0;
            if (line_valid && !bus.i_flush)
                rsp_valid <= NUM_REQ'(1) << line_tag;
            if (line_valid)
                rsp_data <= bus.i_pipe_result;
        end
    end

    assign bus.o_grant      = grant;
    assign bus.o_pipe_valid = pipe_valid;
    assign bus.o_pipe_data  = pipe_data;
    assign bus.o_rsp_valid  = rsp_valid;
    assign bus.o_rsp_data   = rsp_data;
    assign bus.o_idle       = (state == ST_IDLE) & empty;

endmodule

// File: tb/tb_pipe_rr_issuer.sv
// Bench for pipe_rr_issuer: randomized stimulus against a
// time-scheduled reference model of grants, credits and returns.
module tb_pipe_rr_issuer;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int LAT = 3;
    localparam int MO  = 2;

    typedef struct {
        int tag;
        int due;
    } op_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_total = 0;
    int   n_bad = 0;

    pipe_rr_issuer_if #(.NUM_REQ(N), .DWIDTH(DW)) bus ();

    pipe_rr_issuer #(
        .NUM_REQ (N),
        .DWIDTH  (DW),
        .LATENCY (LAT),
        .MAX_OUT (MO)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    wire [9:0] got = {bus.o_grant, bus.o_pipe_valid,
                      bus.o_rsp_valid, bus.o_idle};

    // Model: 0 idle, 1 run, 2 drain
    int          mst;
    int          mptr;
    int          mcnt [N];
    op_t         q [$];
    logic        m_pv;
    logic [DW-1:0] m_pd;
    logic [N-1:0]  m_rv;
    logic [DW-1:0] m_rd;
    int          mcyc;
    int          exp_k;

    function automatic void model_reset();
        mst = 0;
        mptr = 0;
        foreach (mcnt[i]) mcnt[i] = 0;
        q.delete();
        m_pv = 1'b0;
        m_pd = '0;
        m_rv = '0;
        m_rd = '0;
        mcyc = 0;
    endfunction

    function automatic void model_eval();
        int k;
        exp_k = -1;
        if (mst == 1 && bus.i_enable && !bus.i_drain && !bus.i_flush) begin
            for (int i = 0; i < N; i++) begin
                k = (mptr + i) % N;
                if (exp_k < 0 && bus.i_req[k]
                    && (mcnt[k] < MO || m_rv[k]))
                    exp_k = k;
            end
        end
    endfunction

    function automatic logic [9:0] exp_vec();
        logic [N-1:0] g;
        logic idle;
        g = '0;
        if (exp_k >= 0) g[exp_k] = 1'b1;
        idle = (mst == 0) && (q.size() == 0) && (m_rv == 0);
        return {g, m_pv, m_rv, idle};
    endfunction

    function automatic void model_adv();
        case (mst)
            0: if (bus.i_enable) mst = 1;
            1: if (bus.i_drain || !bus.i_enable) mst = 2;
            default:
                if (q.size() == 0 && m_rv == 0 && !bus.i_drain) mst = 0;
        endcase
        if (bus.i_flush) begin
            q.delete();
            m_pv = 1'b0;
            m_rv = '0;
            foreach (mcnt[i]) mcnt[i] = 0;
        end else begin
            for (int j = 0; j < N; j++)
                mcnt[j] += (exp_k == j ? 1 : 0) - (m_rv[j] ? 1 : 0);
            m_rv = '0;
            if (q.size() > 0 && q[0].due == mcyc) begin
                m_rv[q[0].tag] = 1'b1;
                m_rd = bus.i_pipe_result;
                void'(q.pop_front());
            end
            m_pv = (exp_k >= 0);
            if (exp_k >= 0) begin
                q.push_back('{tag: exp_k, due: mcyc + 1 + LAT});
                m_pd = bus.i_req_data[exp_k];
                mptr = (exp_k + 1) % N;
            end
        end
        mcyc++;
    endfunction

    task automatic drive_rand_data();
        for (int k = 0; k < N; k++) bus.i_req_data[k] = $urandom;
        bus.i_pipe_result = $urandom;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.i_enable = 1'b0;
        bus.i_drain = 1'b0;
        bus.i_flush = 1'b0;
        bus.i_req = '0;
        drive_rand_data();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        reset_n = 1'b0;
        @(negedge clk);
        n_total++;
        if ({got, bus.o_pipe_data, bus.o_rsp_data} !== {10'b0000_0_0000_1, 64'd0}) begin
            n_bad++;
            $display("FAIL reset got=%b/%h/%h want=0000000001/0/0",
                     got, bus.o_pipe_data, bus.o_rsp_data);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            drive_rand_data();
            bus.i_enable = 1'b1;
            bus.i_req = (c == 1) ? 4'b0010 : 4'b0000;
            if (c == 5) bus.i_pipe_result = 32'hCAFE;
            @(negedge clk);
            model_eval();
            n_total++;
            if (got !== exp_vec()) begin
                n_bad++;
                $display("FAIL single c=%0d got=%b want=%b", c, got, exp_vec());
            end
            if (m_pv) begin
                n_total++;
                if (bus.o_pipe_data !== m_pd) begin
                    n_bad++;
                    $display("FAIL single pdata c=%0d got=%h want=%h", c, bus.o_pipe_data, m_pd);
                end
            end
            if (c == 1) begin
                n_total++;
                if (bus.o_grant !== 4'b0010) begin
                    n_bad++;
                    $display("FAIL single grant got=%b want=0010", bus.o_grant);
                end
            end
            if (c == 6) begin
                n_total++;
                if ({bus.o_rsp_valid, bus.o_rsp_data} !== {4'b0010, 32'hCAFE}) begin
                    n_bad++;
                    $display("FAIL single rsp got=%b/%h want=0010/cafe",
                             bus.o_rsp_valid, bus.o_rsp_data);
                end
            end
            @(posedge clk);
            model_adv();
            #1;
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] want;
        do_reset();
        for (int c = 0; c < 24; c++) begin
            drive_rand_data();
            bus.i_enable = 1'b1;
            bus.i_req = (c == 0) ? 4'b0000 : 4'b1111;
            @(negedge clk);
            model_eval();
            n_total++;
            if (got !== exp_vec()) begin
                n_bad++;
                $display("FAIL rr c=%0d got=%b want=%b", c, got, exp_vec());
            end
            if (m_rv != 0) begin
                n_total++;
                if (bus.o_rsp_data !== m_rd) begin
                    n_bad++;
                    $display("FAIL rr rdata c=%0d got=%h want=%h", c, bus.o_rsp_data, m_rd);
                end
            end
            if (c >= 1 && c <= 4) begin
                want = 4'b0001 << (c - 1);
                n_total++;
                if (bus.o_grant !== want) begin
                    n_bad++;
                    $display("FAIL rr order c=%0d got=%b want=%b", c, bus.o_grant, want);
                end
            end
            @(posedge clk);
            model_adv();
            #1;
        end
    endtask

    task automatic test_credit();
        logic [N-1:0] want;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            drive_rand_data();
            bus.i_enable = 1'b1;
            bus.i_req = (c == 0) ? 4'b0000 : 4'b0001;
            @(negedge clk);
            model_eval();
            n_total++;
            if (got !== exp_vec()) begin
                n_bad++;
                $display("FAIL credit c=%0d got=%b want=%b", c, got, exp_vec());
            end
            if (c >= 1 && c <= 6) begin
                want = (c <= 2 || c == 6) ? 4'b0001 : 4'b0000;
                n_total++;
                if (bus.o_grant !== want) begin
                    n_bad++;
                    $display("FAIL credit grant c=%0d got=%b want=%b", c, bus.o_grant, want);
                end
            end
            @(posedge clk);
            model_adv();
            #1;
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int c = 0; c < 14; c++) begin
            drive_rand_data();
            bus.i_enable = 1'b1;
            bus.i_flush = (c == 4);
            bus.i_req = (c == 0 || c > 5) ? 4'b0000 : 4'b1111;
            @(negedge clk);
            model_eval();
            n_total++;
            if (got !== exp_vec()) begin
                n_bad++;
                $display("FAIL flush c=%0d got=%b want=%b", c, got, exp_vec());
            end
            if (c == 5) begin
                n_total++;
                if (bus.o_grant !== 4'b1000) begin
                    n_bad++;
                    $display("FAIL flush ptr got=%b want=1000", bus.o_grant);
                end
            end
            if (c >= 5 && c <= 9) begin
                n_total++;
                if (bus.o_rsp_valid !== 4'b0000) begin
                    n_bad++;
                    $display("FAIL flush stale c=%0d got=%b want=0000", c, bus.o_rsp_valid);
                end
            end
            @(posedge clk);
            model_adv();
            #1;
        end
        bus.i_flush = 1'b0;
    endtask

    task automatic test_drain();
        do_reset();
        for (int c = 0; c < 11; c++) begin
            drive_rand_data();
            bus.i_enable = (c < 5);
            bus.i_drain = (c >= 2 && c <= 4);
            bus.i_req = (c == 0) ? 4'b0000 : (c == 1) ? 4'b0001 : 4'b1111;
            @(negedge clk);
            model_eval();
            n_total++;
            if (got !== exp_vec()) begin
                n_bad++;
                $display("FAIL drain c=%0d got=%b want=%b", c, got, exp_vec());
            end
            if (c == 8) begin
                n_total++;
                if (bus.o_idle !== 1'b1) begin
                    n_bad++;
                    $display("FAIL drain idle got=%b want=1", bus.o_idle);
                end
            end
            @(posedge clk);
            model_adv();
            #1;
        end
        bus.i_drain = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            drive_rand_data();
            bus.i_enable = ($urandom_range(0, 15) != 0);
            bus.i_drain = ($urandom_range(0, 11) == 0);
            bus.i_flush = ($urandom_range(0, 29) == 0);
            bus.i_req = N'($urandom);
            @(negedge clk);
            model_eval();
            n_total++;
            if (got !== exp_vec()) begin
                n_bad++;
                $display("FAIL random c=%0d got=%b want=%b", c, got, exp_vec());
            end
            if (m_pv) begin
                n_total++;
                if (bus.o_pipe_data !== m_pd) begin
                    n_bad++;
                    $display("FAIL random pdata c=%0d got=%h want=%h", c, bus.o_pipe_data, m_pd);
                end
            end
            if (m_rv != 0) begin
                n_total++;
                if (bus.o_rsp_data !== m_rd) begin
                    n_bad++;
                    $display("FAIL random rdata c=%0d got=%h want=%h", c, bus.o_rsp_data, m_rd);
                end
            end
            @(posedge clk);
            model_adv();
            #1;
        end
        bus.i_drain = 1'b0;
        bus.i_flush = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.i_enable = 1'b1;
        bus.i_req = 4'b1111;
        repeat (7) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        n_total++;
        if ({got, bus.o_pipe_data, bus.o_rsp_data} !== {10'b0000_0_0000_1, 64'd0}) begin
            n_bad++;
            $display("FAIL async got=%b/%h/%h want=0000000001/0/0",
                     got, bus.o_pipe_data, bus.o_rsp_data);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        model_reset();
        for (int c = 0; c < 4; c++) begin
            drive_rand_data();
            @(negedge clk);
            model_eval();
            n_total++;
            if (got !== exp_vec()) begin
                n_bad++;
                $display("FAIL async c=%0d got=%b want=%b", c, got, exp_vec());
            end
            if (c == 1) begin
                n_total++;
                if (bus.o_grant !== 4'b0001) begin
                    n_bad++;
                    $display("FAIL async first got=%b want=0001", bus.o_grant);
                end
            end
            @(posedge clk);
            model_adv();
            #1;
        end
    endtask

    initial begin
        model_reset();
        exp_k = -1;
        test_reset();
        test_single();
        test_round_robin();
        test_credit();
        test_flush();
        test_drain();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
